// File: rtl/cla_conv_engine.sv
// cla_conv_engine
//   Streaming KSIZE x KSIZE convolution engine. A kernel of KK = KSIZE*KSIZE
//   signed weights is loaded over the weight stream. Each following window of
//   KK signed pixels is multiply-accumulated against the kernel, and the sum is
//   presented on the result handshake.
//
// Parameters
//   DATA_W : signed width of weights and pixels
//   KSIZE  : kernel side (KK = KSIZE*KSIZE elements per window)
//   ACC_W  : signed accumulator/result width, must be >= 2*DATA_W + clog2(KK)
//
// Ports
//   clk_core  in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   cfg_load  in   request to (re)load the kernel
//   wt_valid/wt_data/wt_ready     weight stream handshake
//   pix_valid/pix_data/pix_ready  pixel stream handshake, one element per beat
//   out_valid/out_data/out_ready  result handshake
//   win_cnt   out  completed result transfers (16-bit, wraps)
//   wt_loaded out  a complete kernel is held
//
// Optional feature
//   CLA_CONV_RELU_EN : when defined, negative sums are registered as zero.
module cla_conv_engine #(
    parameter int DATA_W = 8,
    parameter int KSIZE  = 3,
    parameter int ACC_W  = 2 * DATA_W + 4
) (
    input  logic              clk_core,
    input  logic              rst_n,
    input  logic              cfg_load,
    input  logic              wt_valid,
    input  logic [DATA_W-1:0] wt_data,
    output logic              wt_ready,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    input  logic              out_ready,
    output logic [15:0]       win_cnt,
    output logic              wt_loaded
);

    localparam int unsigned KK     = KSIZE * KSIZE;
    localparam int          IDX_W  = (KK > 1) ? $clog2(KK) : 1;
    localparam int          PROD_W = 2 * DATA_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KK - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

    state_t                    state, state_next;
    logic [IDX_W-1:0]          idx;
    logic signed [DATA_W-1:0]  weight [KK];
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   sum_next;
    logic signed [PROD_W-1:0]  prod;
    logic                      idx_last;
    logic                      cfg_take;
    logic                      wt_fire;
    logic                      pix_fire;
    logic                      out_fire;

    // Handshake outputs and next-state decode
    always_comb begin
        wt_ready   = 1'b0;
        pix_ready  = 1'b0;
        out_valid  = 1'b0;
        state_next = state;

        idx_last = (idx == IDX_LAST);
        // A reload is only taken on a window boundary; in RUN it also
        // suppresses pix_ready so a pixel offered that cycle is not consumed.
        cfg_take = cfg_load && ((state == IDLE) || ((state == RUN) && (idx == '0)));

        case (state)
            LOAD: wt_ready = 1'b1;
            RUN:  pix_ready = !cfg_take;
            OUT:  out_valid = 1'b1;
            default: ;
        endcase

        wt_fire  = wt_valid && wt_ready;
        pix_fire = pix_valid && pix_ready;
        out_fire = out_valid && out_ready;

        case (state)
            IDLE: if (cfg_take) state_next = LOAD;
            LOAD: if (wt_fire && idx_last) state_next = RUN;
            RUN: begin
                if (cfg_take)
                    state_next = LOAD;
                else if (pix_fire && idx_last)
                    state_next = OUT;
            end
            OUT:  if (out_fire) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Full-precision signed product, sign-extended into the accumulator
    always_comb begin
        prod     = PROD_W'(weight[idx]) * PROD_W'($signed(pix_data));
        sum_next = acc + ACC_W'(prod);
    end

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            acc       <= '0;
            out_data  <= '0;
            win_cnt   <= '0;
            wt_loaded <= 1'b0;
            for (int unsigned i = 0; i < KK; i++)
                weight[i] <= '0;
        end else begin
            if (cfg_take) begin
                idx       <= '0;
                acc       <= '0;
                wt_loaded <= 1'b0;
            end

            if (wt_fire) begin
                weight[idx] <= wt_data;
                if (idx_last) begin
                    idx       <= '0;
                    wt_loaded <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end

            if (pix_fire) begin
                if (idx_last) begin
                    idx <= '0;
                    acc <= '0;
`ifdef CLA_CONV_RELU_EN
                    out_data <= sum_next[ACC_W-1] ? '0 : sum_next;
`else
                    out_data <= sum_next;
`endif
                end else begin
                    idx <= idx + 1'b1;
                    acc <= sum_next;
                end
            end

            if (out_fire)
                win_cnt <= win_cnt + 16'd1;
        end
    end

endmodule
